fifo_async_write_ptr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous circular FIFO, running entirely in the write clock domain. It tracks the binary and Gray write pointers, gates writes into the dual-port memory, and compares against the Gray read pointer already brought into this domain by the external 2-flop synchronizer. It produces full, almost-full, fill level and a sticky overflow flag. It is the write-domain counterpart of the read-pointer/empty logic.

---
 rtl/fifo_async_write_ptr_ctrl.sv | 95 +++++++++
 tb/tb_fifo_async_write_ptr_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_async_write_ptr_ctrl.sv
// Write-domain pointer/flag controller for an asynchronous circular FIFO.
// Tracks binary and Gray write pointers, gates memory writes, and derives
// full, almost-full, fill level and a sticky overflow flag from the Gray read
// pointer that the external synchronizer has already brought into write_clk.
module fifo_async_write_ptr_ctrl #(
    parameter int unsigned PTR_WIDTH          = 3,
    parameter int unsigned ALMOST_FULL_THRESH = 3
) (
    input  logic                 write_clk,
    input  logic                 nrst_in,
    input  logic                 write_in,
    input  logic                 ovf_clr_in,
    input  logic [PTR_WIDTH-1:0] rptr_g_sync_in,
    output logic                 wen_out,
    output logic [PTR_WIDTH-2:0] waddr_out,
    output logic [PTR_WIDTH-1:0] wptr_b_out,
    output logic [PTR_WIDTH-1:0] wptr_g_out,
    output logic                 full_out,
    output logic                 almost_full_out,
    output logic [PTR_WIDTH-1:0] level_out,
    output logic                 overflow_out
);

    // Inverting the top two Gray bits of the read pointer yields the Gray code
    // of (read pointer + DEPTH), i.e. the write pointer value meaning "full".
    localparam logic [PTR_WIDTH-1:0] FullMask    = PTR_WIDTH'(3) << (PTR_WIDTH - 2);
    localparam logic [PTR_WIDTH-1:0] AfThreshVal = PTR_WIDTH'(ALMOST_FULL_THRESH);

    logic [PTR_WIDTH-1:0] wptr_b_q, wptr_b_d;
    logic [PTR_WIDTH-1:0] wptr_g_q, wptr_g_d;
    logic [PTR_WIDTH-1:0] level_q, level_d;
    logic                 full_q, full_d;
    logic                 almost_full_q, almost_full_d;
    logic                 overflow_q, overflow_d;
    logic [PTR_WIDTH-1:0] rptr_b_sync;
    logic                 wen;

    // Gray-to-binary conversion of the synchronized read pointer.
    always_comb begin
        rptr_b_sync = '0;
        rptr_b_sync[PTR_WIDTH-1] = rptr_g_sync_in[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            rptr_b_sync[i] = rptr_b_sync[i+1] ^ rptr_g_sync_in[i];
        end
    end

    // Write gating and next-state for pointers, level and flags.
    always_comb begin
        wen           = write_in & ~full_q & nrst_in;
        wptr_b_d      = wptr_b_q + PTR_WIDTH'(wen);
        wptr_g_d      = (wptr_b_d >> 1) ^ wptr_b_d;
        level_d       = wptr_b_d - rptr_b_sync;
        full_d        = (wptr_g_d == (rptr_g_sync_in ^ FullMask));
        almost_full_d = (level_d >= AfThreshVal);
        overflow_d    = overflow_q;
        // Set takes priority over clear when both happen together.
        if (write_in && full_q) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_in) begin
            overflow_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge write_clk) begin
        if (!nrst_in) begin
            wptr_b_q      <= '0;
            wptr_g_q      <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wptr_b_q      <= wptr_b_d;
            wptr_g_q      <= wptr_g_d;
            level_q       <= level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    // Output mapping.
    always_comb begin
        wen_out         = wen;
        waddr_out       = wptr_b_q[PTR_WIDTH-2:0];
        wptr_b_out      = wptr_b_q;
        wptr_g_out      = wptr_g_q;
        full_out        = full_q;
        almost_full_out = almost_full_q;
        level_out       = level_q;
        overflow_out    = overflow_q;
    end

endmodule

// File: tb/tb_fifo_async_write_ptr_ctrl.sv
// Self-checking bench for fifo_async_write_ptr_ctrl: directed scenarios then
// randomized traffic, all compared against an occupancy model that counts
// absolute writes and reads and derives pointers and flags from them.
module tb_fifo_async_write_ptr_ctrl;

    localparam int PW     = 3;
    localparam int THRESH = 3;
    localparam int DEPTH  = 1 << (PW - 1);
    localparam int MOD    = 1 << PW;

    logic          write_clk = 1'b0;
    logic          nrst_in = 1'b0;
    logic          write_in = 1'b0;
    logic          ovf_clr_in = 1'b0;
    logic [PW-1:0] rptr_g_sync_in = '0;
    logic          wen_out;
    logic [PW-2:0] waddr_out;
    logic [PW-1:0] wptr_b_out;
    logic [PW-1:0] wptr_g_out;
    logic          full_out;
    logic          almost_full_out;
    logic [PW-1:0] level_out;
    logic          overflow_out;

    fifo_async_write_ptr_ctrl #(
        .PTR_WIDTH          (PW),
        .ALMOST_FULL_THRESH (THRESH)
    ) dut (
        .write_clk       (write_clk),
        .nrst_in         (nrst_in),
        .write_in        (write_in),
        .ovf_clr_in      (ovf_clr_in),
        .rptr_g_sync_in  (rptr_g_sync_in),
        .wen_out         (wen_out),
        .waddr_out       (waddr_out),
        .wptr_b_out      (wptr_b_out),
        .wptr_g_out      (wptr_g_out),
        .full_out        (full_out),
        .almost_full_out (almost_full_out),
        .level_out       (level_out),
        .overflow_out    (overflow_out)
    );

    always #5 write_clk = ~write_clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: absolute counts of accepted writes and of reads seen.
    int m_w    = 0;
    int r_cnt  = 0;
    bit m_full = 0;
    bit m_af   = 0;
    bit m_ovf  = 0;
    int m_lvl  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_gray(input int v);
        int b;
        b = v % MOD;
        return b ^ (b >> 1);
    endfunction

    // One write_clk cycle: drive inputs, check wen, advance model, check outputs.
    task automatic step(input bit wr, input bit clr, input bit rst_act, input int rtgt);
        int exp_wen;
        @(negedge write_clk);
        write_in       = wr;
        ovf_clr_in     = clr;
        nrst_in        = !rst_act;
        r_cnt          = rst_act ? 0 : rtgt;
        rptr_g_sync_in = PW'(to_gray(r_cnt));
        #1;
        exp_wen = (wr && !m_full && !rst_act) ? 1 : 0;
        check_eq("wen", int'(wen_out), exp_wen);
        @(posedge write_clk);
        if (rst_act) begin
            m_w = 0; m_full = 0; m_af = 0; m_ovf = 0; m_lvl = 0;
        end else begin
            if (exp_wen == 1) m_w++;
            if (wr && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_lvl  = m_w - r_cnt;
            m_full = (m_lvl == DEPTH);
            m_af   = (m_lvl >= THRESH);
        end
        #1;
        check_eq("wptr_b", int'(wptr_b_out), m_w % MOD);
        check_eq("wptr_g", int'(wptr_g_out), to_gray(m_w));
        check_eq("waddr", int'(waddr_out), m_w % DEPTH);
        check_eq("level", int'(level_out), m_lvl);
        check_eq("full", int'(full_out), int'(m_full));
        check_eq("almost_full", int'(almost_full_out), int'(m_af));
        check_eq("overflow", int'(overflow_out), int'(m_ovf));
    endtask

    initial begin
        int rt;
        // Reset held for two cycles with a write request pending.
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        // Fill to full against a stationary reader.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            if (i == 0) check_eq("first_write_g", int'(wptr_g_out), 1);
        end
        check_eq("fill_g", int'(wptr_g_out), 6);
        check_eq("fill_full", int'(full_out), 1);
        // Overflow attempt, hold, clear, then attempt+clear together.
        step(1, 0, 0, 0);
        check_eq("ovf_wptr_hold", int'(wptr_b_out), 4);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check_eq("ovf_cleared", int'(overflow_out), 0);
        step(1, 1, 0, 0);
        check_eq("ovf_set_wins", int'(overflow_out), 1);
        // Drain: reader jumps to the writer.
        step(0, 1, 0, 4);
        check_eq("drain_level", int'(level_out), 0);
        // Refill, then a read advance coinciding with a blocked write.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4);
        step(1, 0, 0, 5);
        check_eq("simul_level", int'(level_out), 3);
        step(1, 0, 0, 5);
        check_eq("simul_accept", int'(level_out), 4);
        // Wrap with reader trailing by one entry.
        step(0, 0, 0, m_w);
        for (int i = 0; i < 10; i++) step(1, 0, 0, m_w);
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 500; i++) begin
            rt = r_cnt;
            if (r_cnt < m_w && ($urandom % 2) == 1) rt = r_cnt + 1;
            if (($urandom % 16) == 0) rt = m_w;
            step(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 64) == 0, rt);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
